irq_line_dispatcher: RTL and testbench

- Responder side of the 20-line request fan-in. The wide OR only reports "something is requesting"; this block captures each line, offers the winning line number to the CPU interrupt logic, and returns a one-cycle per-line Clear pulse to the requesting source when the CPU acknowledges.
- Sits between peripheral request lines and the RISC-V core's interrupt entry/exit logic.

---
 rtl/irq_line_dispatcher_if.sv | 37 +++
 rtl/irq_line_dispatcher.sv | 89 ++++++++
 tb/tb_irq_line_dispatcher.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/irq_line_dispatcher_if.sv
// Request-line / CPU-side bundle for irq_line_dispatcher.
// Optional Ack_Count signal present when IRQ_ACK_COUNT_EN is defined.
interface irq_line_dispatcher_if #(
    parameter int NUM_LINES = 20,
    parameter int NUM_W     = 5
);
    logic [NUM_LINES-1:0] req;
    logic [NUM_LINES-1:0] enable_mask;
    logic                 any_pending;
    logic                 irq_valid;
    logic [NUM_W-1:0]     irq_num;
    logic                 irq_ack;
    logic                 irq_done;
    logic [NUM_LINES-1:0] clear;
    logic                 busy;
`ifdef IRQ_ACK_COUNT_EN
    logic [15:0]          ack_count;
`endif

    // Sources + CPU side
    modport master (
        output req, enable_mask, irq_ack, irq_done,
        input  any_pending, irq_valid, irq_num, clear, busy
`ifdef IRQ_ACK_COUNT_EN
        , input ack_count
`endif
    );

    // Dispatcher side
    modport slave (
        input  req, enable_mask, irq_ack, irq_done,
        output any_pending, irq_valid, irq_num, clear, busy
`ifdef IRQ_ACK_COUNT_EN
        , output ack_count
`endif
    );
endinterface

// File: rtl/irq_line_dispatcher.sv
// Interrupt line dispatcher: captures rising edges on request lines, offers
// the lowest-index enabled pending line to the CPU, pulses Clear on ack and
// holds Busy until the handler reports done.
// Optional macro IRQ_ACK_COUNT_EN adds a 16-bit wrapping accepted-ack counter.
module irq_line_dispatcher #(
    parameter int                   NUM_LINES    = 20,
    parameter logic [NUM_LINES-1:0] BUBBLES_MASK = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    irq_line_dispatcher_if.slave bus
);
    localparam int NUM_W = $clog2(NUM_LINES);

    typedef enum logic [1:0] {IDLE, OFFER, SERVICE} state_t;

    state_t               state_q, state_d;
    logic [NUM_LINES-1:0] prev_q, pending_q, clear_q;
    logic [NUM_LINES-1:0] lvl, rise, eligible, offer_mask, clr_mask;
    logic [NUM_W-1:0]     irq_num_q, win;
    logic                 ack_accept;

    assign lvl        = bus.req ^ BUBBLES_MASK;
    assign rise       = lvl & ~prev_q;
    assign eligible   = pending_q & bus.enable_mask;
    assign offer_mask = NUM_LINES'(1) << irq_num_q;
    assign ack_accept = (state_q == OFFER) && bus.irq_ack;
    assign clr_mask   = ack_accept ? offer_mask : '0;

    // Lowest set index of eligible wins
    always_comb begin
        win = '0;
        for (int i = NUM_LINES - 1; i >= 0; i--)
            if (eligible[i]) win = NUM_W'(i);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: offer stays fixed until acked or its line becomes ineligible
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|eligible) state_d = OFFER;
            OFFER: begin
                if (bus.irq_ack)                      state_d = SERVICE;
                else if (~|(eligible & offer_mask))   state_d = IDLE;
            end
            SERVICE: if (bus.irq_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Edge capture, sticky pending (set beats clear), clear pulse, offer latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q    <= '0;
            pending_q <= '0;
            clear_q   <= '0;
            irq_num_q <= '0;
        end else begin
            prev_q    <= lvl;
            pending_q <= (pending_q & ~clr_mask) | rise;
            clear_q   <= clr_mask;
            if (state_q == IDLE && |eligible) irq_num_q <= win;
        end
    end

`ifdef IRQ_ACK_COUNT_EN
    logic [15:0] ack_count_q;

    // Count accepted acks, wrapping naturally at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             ack_count_q <= '0;
        else if (ack_accept) ack_count_q <= ack_count_q + 16'd1;
    end

    assign bus.ack_count = ack_count_q;
`endif

    assign bus.any_pending = |eligible;
    assign bus.irq_valid   = (state_q == OFFER);
    assign bus.irq_num     = irq_num_q;
    assign bus.clear       = clear_q;
    assign bus.busy        = (state_q == SERVICE);
endmodule

// File: tb/tb_irq_line_dispatcher.sv
// Self-checking bench for irq_line_dispatcher: vector table, directed
// multi-cycle corner sequences, and random stimulus against a line-level model.
module tb_irq_line_dispatcher;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    irq_line_dispatcher_if #(.NUM_LINES(20), .NUM_W(5)) bus ();
    irq_line_dispatcher_if #(.NUM_LINES(20), .NUM_W(5)) bbus ();

    irq_line_dispatcher #(.NUM_LINES(20), .BUBBLES_MASK(20'h00000)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave));
    irq_line_dispatcher #(.NUM_LINES(20), .BUBBLES_MASK(20'h00001)) dut_b (
        .clk(clk), .rst(rst), .bus(bbus.slave));

    int total = 0;
    int bad   = 0;

    // Reference model: which line is offered (-1 none), whether a handler runs
    int       m_offer, m_num, m_clr, m_acks;
    bit       m_serving;
    bit [19:0] m_pend, m_prev;

    typedef struct {
        logic [19:0] req;
        logic        ack, done;
        logic        valid;
        logic [4:0]  num;
        logic        busy;
        logic [19:0] clr;
        logic        anyp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_offer = -1; m_num = 0; m_clr = -1; m_acks = 0;
        m_serving = 0; m_pend = '0; m_prev = '0;
    endfunction

    function automatic void model_step(bit [19:0] rq, bit [19:0] en, bit ack, bit done);
        bit [19:0] rise;
        rise  = rq & ~m_prev;
        m_clr = -1;
        if (m_offer >= 0) begin
            if (ack) begin
                m_pend[m_offer] = 1'b0;
                m_clr     = m_offer;
                m_serving = 1'b1;
                m_offer   = -1;
                m_acks    = (m_acks + 1) % 65536;
            end else if (!(m_pend[m_offer] && en[m_offer])) begin
                m_offer = -1;
            end
        end else if (m_serving) begin
            if (done) m_serving = 1'b0;
        end else begin
            for (int i = 0; i < 20; i++)
                if (m_pend[i] && en[i]) begin
                    m_offer = i; m_num = i; break;
                end
        end
        m_pend = m_pend | rise;
        m_prev = rq;
    endfunction

    // One clock: drive main inputs, advance model, compare all main outputs
    task automatic cycle(input logic [19:0] rq, input logic [19:0] en,
                         input logic ack, input logic done);
        logic [19:0] exp_clr;
        bus.req = rq; bus.enable_mask = en; bus.irq_ack = ack; bus.irq_done = done;
        @(posedge clk);
        model_step(rq, en, ack, done);
        #1;
        exp_clr = (m_clr >= 0) ? (20'(1) << m_clr) : 20'h0;
        chk("valid", 32'(bus.irq_valid), 32'(m_offer >= 0));
        chk("num",   32'(bus.irq_num),   32'(m_num));
        chk("busy",  32'(bus.busy),      32'(m_serving));
        chk("clear", 32'(bus.clear),     32'(exp_clr));
        chk("anyp",  32'(bus.any_pending), 32'(|(m_pend & en)));
`ifdef IRQ_ACK_COUNT_EN
        chk("ack_count", 32'(bus.ack_count), 32'(m_acks));
`endif
    endtask

    vec_t vt[14];
    logic [19:0] rq;
    logic [19:0] en;

    initial begin
        // Line 3 path, then lines 2 and 5 together
        vt[0]  = '{20'h00000, 0, 0, 0, 5'd0, 0, 20'h00000, 0};
        vt[1]  = '{20'h00008, 0, 0, 0, 5'd0, 0, 20'h00000, 1};
        vt[2]  = '{20'h00008, 0, 0, 1, 5'd3, 0, 20'h00000, 1};
        vt[3]  = '{20'h00008, 1, 0, 0, 5'd3, 1, 20'h00008, 0};
        vt[4]  = '{20'h00008, 0, 0, 0, 5'd3, 1, 20'h00000, 0};
        vt[5]  = '{20'h00008, 0, 1, 0, 5'd3, 0, 20'h00000, 0};
        vt[6]  = '{20'h0002C, 0, 0, 0, 5'd3, 0, 20'h00000, 1};
        vt[7]  = '{20'h0002C, 0, 0, 1, 5'd2, 0, 20'h00000, 1};
        vt[8]  = '{20'h0002C, 1, 0, 0, 5'd2, 1, 20'h00004, 1};
        vt[9]  = '{20'h0002C, 0, 0, 0, 5'd2, 1, 20'h00000, 1};
        vt[10] = '{20'h0002C, 0, 1, 0, 5'd2, 0, 20'h00000, 1};
        vt[11] = '{20'h0002C, 0, 0, 1, 5'd5, 0, 20'h00000, 1};
        vt[12] = '{20'h0002C, 1, 0, 0, 5'd5, 1, 20'h00020, 0};
        vt[13] = '{20'h0002C, 0, 1, 0, 5'd5, 0, 20'h00000, 0};

        bus.req = '0; bus.enable_mask = 20'hFFFFF; bus.irq_ack = 0; bus.irq_done = 0;
        bbus.req = 20'h00001; bbus.enable_mask = 20'hFFFFF; bbus.irq_ack = 0; bbus.irq_done = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.irq_valid), 0);
        chk("rst_busy",  32'(bus.busy), 0);
        chk("rst_clear", 32'(bus.clear), 0);
        chk("rst_anyp",  32'(bus.any_pending), 0);
        chk("rst_num",   32'(bus.irq_num), 0);
`ifdef IRQ_ACK_COUNT_EN
        chk("rst_ack_count", 32'(bus.ack_count), 0);
`endif
        rst = 1'b0;

        // Inverted line 0 held high through reset: no capture until it falls
        cycle(20'h0, 20'hFFFFF, 0, 0);
        cycle(20'h0, 20'hFFFFF, 0, 0);
        chk("bub_idle", 32'(bbus.irq_valid), 0);
        bbus.req = 20'h0;
        cycle(20'h0, 20'hFFFFF, 0, 0);
        chk("bub_anyp", 32'(bbus.any_pending), 1);
        cycle(20'h0, 20'hFFFFF, 0, 0);
        chk("bub_valid", 32'(bbus.irq_valid), 1);
        chk("bub_num",   32'(bbus.irq_num), 0);
        bbus.irq_ack = 1;
        cycle(20'h0, 20'hFFFFF, 0, 0);
        chk("bub_clear", 32'(bbus.clear), 1);
        bbus.irq_ack = 0; bbus.irq_done = 1;
        cycle(20'h0, 20'hFFFFF, 0, 0);
        bbus.irq_done = 0; bbus.req = 20'h00001;
        cycle(20'h0, 20'hFFFFF, 0, 0);
        cycle(20'h0, 20'hFFFFF, 0, 0);
        chk("bub_rise_nocap_anyp",  32'(bbus.any_pending), 0);
        chk("bub_rise_nocap_valid", 32'(bbus.irq_valid), 0);

        // Vector table
        for (int i = 0; i < 14; i++) begin
            cycle(vt[i].req, 20'hFFFFF, vt[i].ack, vt[i].done);
            chk($sformatf("vec%0d_valid", i), 32'(bus.irq_valid),   32'(vt[i].valid));
            chk($sformatf("vec%0d_num", i),   32'(bus.irq_num),     32'(vt[i].num));
            chk($sformatf("vec%0d_busy", i),  32'(bus.busy),        32'(vt[i].busy));
            chk($sformatf("vec%0d_clear", i), 32'(bus.clear),       32'(vt[i].clr));
            chk($sformatf("vec%0d_anyp", i),  32'(bus.any_pending), 32'(vt[i].anyp));
        end

        // Offer on line 7 withdrawn by masking, re-offered on unmask
        cycle(20'h00080, 20'hFFFFF, 0, 0);
        cycle(20'h00080, 20'hFFFFF, 0, 0);
        chk("mask_offer", 32'(bus.irq_num), 7);
        cycle(20'h00080, 20'hFFF7F, 0, 0);
        chk("mask_drop_valid", 32'(bus.irq_valid), 0);
        cycle(20'h00080, 20'hFFF7F, 0, 0);
        chk("mask_idle_valid", 32'(bus.irq_valid), 0);
        cycle(20'h00080, 20'hFFFFF, 0, 0);
        chk("mask_reoffer_valid", 32'(bus.irq_valid), 1);
        chk("mask_reoffer_num",   32'(bus.irq_num), 7);

        // Fresh edge on the offered line in the ack cycle: set wins
        cycle(20'h00000, 20'hFFFFF, 0, 0);
        cycle(20'h00080, 20'hFFFFF, 1, 0);
        chk("same_clear", 32'(bus.clear), 32'h80);
        chk("same_anyp",  32'(bus.any_pending), 1);
        cycle(20'h00080, 20'hFFFFF, 0, 1);
        cycle(20'h00080, 20'hFFFFF, 0, 0);
        chk("same_reoffer_valid", 32'(bus.irq_valid), 1);
        chk("same_reoffer_num",   32'(bus.irq_num), 7);
        cycle(20'h00080, 20'hFFFFF, 1, 0);
        cycle(20'h00080, 20'hFFFFF, 0, 1);

        // Asynchronous reset while in service with Clear high
        cycle(20'h00081, 20'hFFFFF, 0, 0);
        cycle(20'h00081, 20'hFFFFF, 0, 0);
        cycle(20'h00081, 20'hFFFFF, 1, 0);
        chk("pre_arst_clear", 32'(bus.clear), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.irq_valid), 0);
        chk("arst_busy",  32'(bus.busy), 0);
        chk("arst_clear", 32'(bus.clear), 0);
        chk("arst_anyp",  32'(bus.any_pending), 0);
        chk("arst_num",   32'(bus.irq_num), 0);
`ifdef IRQ_ACK_COUNT_EN
        chk("arst_ack_count", 32'(bus.ack_count), 0);
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Random traffic against the model
        rq = 20'h00081;
        en = 20'hFFFFF;
        for (int n = 0; n < 600; n++) begin
            rq ^= 20'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 9) == 0)
                en = ($urandom_range(0, 1) == 0) ? 20'hFFFFF : 20'($urandom);
            cycle(rq, en, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
